// File: rtl/transposer_col_drain.sv
// Receive side of the always-valid transposer column stream. It counts row beats to locate each tile,
// captures DIM columns per tile into a FIFO, and re-issues them on valid/ready with a tile-last marker.
// Optional feature macro: TRANSPOSER_DRAIN_TILE_ID_EN (adds out_tile_id and a per-entry tile counter).
module transposer_col_drain #(
  parameter int DIM   = 16,
  parameter int W     = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_row_valid,
  input  logic [DIM*W-1:0]         in_col_data,
  output logic                     out_valid,
  output logic [DIM*W-1:0]         out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
  ,
  output logic [7:0]               out_tile_id
`endif
);

  localparam int CW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PW   = $clog2(LAT + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;
  localparam int DW   = DIM * W;
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
  localparam int EW   = DW + 1 + 8;
`else
  localparam int EW   = DW + 1;
`endif

  localparam logic [CW-1:0]   LAST_IDX = CW'(DIM - 1);
  localparam logic [PW-1:0]   LAT_V    = PW'(LAT);
  localparam logic [PW-1:0]   PEND_ONE = PW'(1);
  localparam logic [PTRW-1:0] DEPTH_V  = PTRW'(DEPTH);

  // Handshake: a head entry transfers on any rising edge where out_valid && out_ready;
  // out_valid never drops and out_data/out_last never change until that transfer happens.

  logic [CW-1:0]   row_cnt_q, row_cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            drain_q, drain_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            overflow_q, overflow_d;
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
  logic [7:0]      tile_cnt_q, tile_cnt_d;
  logic [7:0]      out_tile_id_q, out_tile_id_d;
`endif

  logic [EW-1:0]   mem_q [DEPTH];

  logic            wrap;
  logic            push;
  logic [CW-1:0]   cur_idx;
  logic            col_last;
  logic [PTRW-1:0] count;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic [EW-1:0]   push_word;
  logic [EW-1:0]   head_word;

  always_comb begin
    row_cnt_d   = row_cnt_q;
    pend_d      = pend_q;
    drain_d     = drain_q;
    col_idx_d   = col_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
    tile_cnt_d    = tile_cnt_q;
    out_tile_id_d = out_tile_id_q;
`endif

    wrap = in_row_valid && (row_cnt_q == LAST_IDX);
    if (in_row_valid) begin
      row_cnt_d = wrap ? '0 : row_cnt_q + 1'b1;
    end

    // The pend timer re-arms on a wrap even while a window is draining.
    if (wrap) begin
      pend_d = LAT_V;
    end else if (pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end

    push     = (pend_q == PEND_ONE) || drain_q;
    cur_idx  = drain_q ? col_idx_q : '0;
    col_last = (cur_idx == LAST_IDX);
    if (push) begin
      drain_d   = !col_last;
      col_idx_d = col_last ? '0 : cur_idx + 1'b1;
    end

    count = wr_ptr_q - rd_ptr_q;
    full  = (count == DEPTH_V);
    pop   = out_valid_q && out_ready;
    wr_en = push && (!full || pop);

    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end

`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
    push_word = {tile_cnt_q, col_last, in_col_data};
    if (push && col_last) begin
      tile_cnt_d = tile_cnt_q + 8'd1;
    end
`else
    push_word = {col_last, in_col_data};
`endif

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Bypass covers the entry being written this cycle becoming the next head.
    head_word   = (wr_en && (wr_ptr_q == rd_ptr_d)) ? push_word : mem_q[rd_ptr_d[AW-1:0]];
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    if (out_valid_d) begin
      out_data_d = head_word[DW-1:0];
      out_last_d = head_word[DW];
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
      out_tile_id_d = head_word[EW-1 -: 8];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt_q   <= '0;
      pend_q      <= '0;
      drain_q     <= 1'b0;
      col_idx_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
      tile_cnt_q    <= '0;
      out_tile_id_q <= '0;
`endif
    end else begin
      row_cnt_q   <= row_cnt_d;
      pend_q      <= pend_d;
      drain_q     <= drain_d;
      col_idx_q   <= col_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
      tile_cnt_q    <= tile_cnt_d;
      out_tile_id_q <= out_tile_id_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign fifo_count = count;
`ifdef TRANSPOSER_DRAIN_TILE_ID_EN
  assign out_tile_id = out_tile_id_q;
`endif

  a_head_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_last_q)));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= DEPTH_V);

endmodule
